pattern_writer: RTL and testbench

PATTERN_WRITER -- requirements
Module: pattern_writer

---
 rtl/pattern_writer.sv | 179 +++++++++++++++++
 tb/tb_pattern_writer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_writer.sv
// pattern_writer
//
// Packs a byte stream into 36-bit words and writes them, one word per
// write strobe, into consecutive addresses 0 .. 2**ADDR_BITS-1 of a memory
// port A. Five bytes form one word: bytes 0..3 fill bits [31:0]
// little-endian, and the low nibble of byte 4 fills bits [35:32].
//
// Optional feature macro: PATTERN_WRITER_CHECKSUM_EN
//   defined   -> checksum is the modulo-256 sum of all bytes accepted
//                since the last start
//   undefined -> checksum is tied to zero
//
// Ports
//   clk       in   clock, all logic on the rising edge
//   rst_n     in   synchronous active-low reset
//   start     in   one-cycle pulse, (re)starts a fill at address 0
//   in_data   in   [7:0] byte stream data
//   in_valid  in   in_data valid
//   in_ready  out  byte taken when in_valid && in_ready
//   wea       out  memory write enable
//   addra     out  [12:0] memory address, upper bits zero
//   dina      out  [WORD_BITS-1:0] memory write data
//   busy      out  fill in progress
//   done      out  last word written, held until start or reset
//   checksum  out  [7:0] running byte sum (see macro above)

module pattern_writer #(
    parameter int ADDR_BITS = 7,
    parameter int WORD_BITS = 36
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 wea,
    output logic [12:0]          addra,
    output logic [WORD_BITS-1:0] dina,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           checksum
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [2:0]             idx_q, idx_d;
    logic [WORD_BITS-1:0]   word_q, word_d;
    logic [12:0]            addra_q, addra_d;
    logic [WORD_BITS-1:0]   dina_q, dina_d;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        idx_d    = idx_q;
        word_d   = word_q;
        addra_d  = addra_q;
        dina_d   = dina_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        wea      = 1'b0;

        case (state_q)
            IDLE: begin
            end
            COLLECT: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    case (idx_q)
                        3'd0:    word_d[7:0]   = in_data;
                        3'd1:    word_d[15:8]  = in_data;
                        3'd2:    word_d[23:16] = in_data;
                        3'd3:    word_d[31:24] = in_data;
                        default: word_d[35:32] = in_data[3:0];
                    endcase
                    if (idx_q == 3'd4) begin
                        // Word complete: latch the memory outputs now so
                        // they are stable for the single WRITE cycle.
                        idx_d   = 3'd0;
                        state_d = WRITE;
                        dina_d  = word_d;
                        addra_d = 13'(addr_q);
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            WRITE: begin
                busy = 1'b1;
                // Gated by rst_n so a reset landing on the write cycle
                // never lets a strobe through.
                wea    = rst_n;
                word_d = '0;
                if (addr_q == LAST_ADDR) begin
                    state_d = DONE;
                end else begin
                    addr_d  = addr_q + ADDR_BITS'(1);
                    state_d = COLLECT;
                end
            end
            default: begin
                done = 1'b1;
            end
        endcase

        // A start in any state restarts the fill; it also cancels a write
        // strobe and any byte presented in the same cycle.
        if (start) begin
            state_d = COLLECT;
            addr_d  = '0;
            idx_d   = 3'd0;
            word_d  = '0;
            addra_d = addra_q;
            dina_d  = dina_q;
            wea     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            idx_q   <= 3'd0;
            word_q  <= '0;
            addra_q <= '0;
            dina_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            addra_q <= addra_d;
            dina_q  <= dina_d;
        end
    end

    assign addra = addra_q;
    assign dina  = dina_q;

`ifdef PATTERN_WRITER_CHECKSUM_EN
    logic       accept;
    logic [7:0] checksum_q, checksum_d;

    assign accept = (state_q == COLLECT) && in_valid;

    always_comb begin
        checksum_d = checksum_q;
        if (start) begin
            checksum_d = 8'd0;
        end else if (accept) begin
            checksum_d = checksum_q + in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            checksum_q <= 8'd0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = 8'd0;
`endif

endmodule

// File: tb/tb_pattern_writer.sv
// tb_pattern_writer
//
// Self-checking bench for pattern_writer: a table of single-cycle vectors
// covering reset, reset-versus-start priority and one complete word,
// followed by hand-written multi-cycle sequences (full fill, throttled
// fill, restart in COLLECT and WRITE, reset during WRITE).

module tb_pattern_writer;

    typedef struct {
        logic        rstN;
        logic        start;
        logic        valid;
        logic [7:0]  data;
        logic        expReady;
        logic        expBusy;
        logic        expDone;
        logic        expWea;
        logic [12:0] expAddra;
        logic [35:0] expDina;
        logic [7:0]  expCk;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wea;
    logic [12:0] addra;
    logic [35:0] dina;
    logic        busy;
    logic        done;
    logic [7:0]  checksum;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [12:0] wrAddr[$];
    logic [35:0] wrData[$];
    int          wrCyc[$];

    vec_t vecs[10];

    pattern_writer #(
        .ADDR_BITS(7),
        .WORD_BITS(36)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wea      (wea),
        .addra    (addra),
        .dina     (dina),
        .busy     (busy),
        .done     (done),
        .checksum (checksum)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Log every write strobe seen at the falling edge.
    always @(negedge clk) begin
        if (wea === 1'b1) begin
            wrAddr.push_back(addra);
            wrData.push_back(dina);
            wrCyc.push_back(cyc);
        end
    end

    // Absolute time limit so the bench always ends.
    initial begin
        #600000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] expCk(input logic [7:0] v);
`ifdef PATTERN_WRITER_CHECKSUM_EN
        return v;
`else
        return 8'd0 & v;
`endif
    endfunction

    function automatic logic [7:0] pat(input int k);
        return 8'((k * 37) + 11);
    endfunction

    function automatic logic [35:0] wordOf(input int w);
        logic [7:0] b4;
        b4 = pat(5 * w + 4);
        return {b4[3:0], pat(5 * w + 3), pat(5 * w + 2), pat(5 * w + 1), pat(5 * w)};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, ".in_ready"}, 64'(in_ready), 0);
        checkOutput({tag, ".busy"}, 64'(busy), 0);
        checkOutput({tag, ".done"}, 64'(done), 0);
        checkOutput({tag, ".wea"}, 64'(wea), 0);
        checkOutput({tag, ".addra"}, 64'(addra), 0);
        checkOutput({tag, ".dina"}, 64'(dina), 0);
        checkOutput({tag, ".checksum"}, 64'(checksum), 0);
    endtask

    task automatic clearLog();
        wrAddr.delete();
        wrData.delete();
        wrCyc.delete();
    endtask

    // Leaves the bench at posedge+1 with rst_n released.
    task automatic doReset(input bit checkIt);
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        if (checkIt) begin
            @(negedge clk);
            checkResetOutputs("reset");
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Presents one byte and holds it until accepted (bounded wait).
    task automatic sendByte(input logic [7:0] d);
        bit got;
        got      = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checkOutput("byteAccepted", 64'(got), 1);
    endtask

    task automatic applyStimulus(input vec_t v, input int n);
        string tag;
        tag      = $sformatf("vec%0d", n);
        rst_n    = v.rstN;
        start    = v.start;
        in_valid = v.valid;
        in_data  = v.data;
        @(negedge clk);
        checkOutput({tag, ".in_ready"}, 64'(in_ready), 64'(v.expReady));
        checkOutput({tag, ".busy"}, 64'(busy), 64'(v.expBusy));
        checkOutput({tag, ".done"}, 64'(done), 64'(v.expDone));
        checkOutput({tag, ".wea"}, 64'(wea), 64'(v.expWea));
        checkOutput({tag, ".addra"}, 64'(addra), 64'(v.expAddra));
        checkOutput({tag, ".dina"}, 64'(dina), 64'(v.expDina));
        checkOutput({tag, ".checksum"}, 64'(checksum), 64'(v.expCk));
        @(posedge clk);
        #1;
    endtask

    // Fills the whole region; toggle inserts an idle cycle after every byte.
    task automatic runFill(input bit toggle);
        string tag;
        int    n;
        tag = toggle ? "toggleFill" : "fullFill";
        doReset(1'b0);
        clearLog();
        pulseStart();
        for (int k = 0; k < 640; k++) begin
            sendByte(pat(k));
            if (toggle) begin
                @(posedge clk);
                #1;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput({tag, ".done"}, 64'(done), 1);
        checkOutput({tag, ".in_ready"}, 64'(in_ready), 0);
        checkOutput({tag, ".busy"}, 64'(busy), 0);
        checkOutput({tag, ".nWrites"}, 64'(wrAddr.size()), 128);
        n = (wrAddr.size() < 128) ? wrAddr.size() : 128;
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s.addr%0d", tag, i), 64'(wrAddr[i]), 64'(i));
            checkOutput($sformatf("%s.data%0d", tag, i), 64'(wrData[i]), 64'(wordOf(i)));
            if (!toggle && i > 0) begin
                checkOutput($sformatf("%s.gap%0d", tag, i), 64'(wrCyc[i] - wrCyc[i-1]), 6);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        //            rst  st  vld data   rdy bsy dne wea addra  dina               ck
        vecs[0] = '{1'b0, 1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 13'd0, 36'h0, expCk(8'h00)};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 13'd0, 36'h0, expCk(8'h00)};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 13'd0, 36'h0, expCk(8'h00)};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 13'd0, 36'h0, expCk(8'h00)};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0, 13'd0, 36'h0, expCk(8'h01)};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 1'b0, 13'd0, 36'h0, expCk(8'h03)};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 8'h04, 1'b1, 1'b1, 1'b0, 1'b0, 13'd0, 36'h0, expCk(8'h06)};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 8'hF5, 1'b1, 1'b1, 1'b0, 1'b0, 13'd0, 36'h0, expCk(8'h0A)};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 13'd0, 36'h5_0403_0201, expCk(8'hFF)};
        vecs[9] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 13'd0, 36'h5_0403_0201, expCk(8'hFF)};

        // Reset state, then the vector table.
        doReset(1'b1);
        rst_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Continuous and throttled fills of the whole region.
        runFill(1'b0);
        runFill(1'b1);

        // Restart after three bytes of word 5.
        doReset(1'b0);
        clearLog();
        pulseStart();
        for (int k = 0; k < 28; k++) sendByte(pat(k));
        start = 1'b1;
        @(negedge clk);
        checkOutput("restartCollect.wea", 64'(wea), 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        sendByte(8'h11);
        sendByte(8'h22);
        sendByte(8'h33);
        sendByte(8'h44);
        sendByte(8'h9E);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("restartCollect.nWrites", 64'(wrAddr.size()), 6);
        for (int i = 0; i < 5 && i < wrAddr.size(); i++) begin
            checkOutput($sformatf("restartCollect.addr%0d", i), 64'(wrAddr[i]), 64'(i));
        end
        if (wrAddr.size() > 5) begin
            checkOutput("restartCollect.newAddr", 64'(wrAddr[5]), 0);
            checkOutput("restartCollect.newData", 64'(wrData[5]), 64'(36'hE_4433_2211));
        end
        checkOutput("restartCollect.checksum", 64'(checksum), 64'(expCk(8'h48)));
        @(posedge clk);
        #1;

        // Start landing on the WRITE cycle of address 1.
        for (int k = 1; k <= 5; k++) sendByte(8'(k));
        start = 1'b1;
        @(negedge clk);
        checkOutput("restartWrite.wea", 64'(wea), 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("restartWrite.busy", 64'(busy), 1);
        checkOutput("restartWrite.in_ready", 64'(in_ready), 1);
        @(posedge clk);
        #1;
        sendByte(8'hA0);
        sendByte(8'hA1);
        sendByte(8'hA2);
        sendByte(8'hA3);
        sendByte(8'hA4);
        @(negedge clk);
        checkOutput("restartWrite.nextWea", 64'(wea), 1);
        checkOutput("restartWrite.nextAddra", 64'(addra), 0);
        checkOutput("restartWrite.nextDina", 64'(dina), 64'(36'h4_A3A2_A1A0));
        @(posedge clk);
        #1;
        checkOutput("restartWrite.nWrites", 64'(wrAddr.size()), 7);

        // Reset for one cycle during the WRITE of address 10.
        doReset(1'b0);
        clearLog();
        pulseStart();
        for (int k = 0; k < 55; k++) sendByte(pat(k));
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("resetInWrite.wea", 64'(wea), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkResetOutputs("resetInWrite");
        checkOutput("resetInWrite.nWrites", 64'(wrAddr.size()), 10);
        @(posedge clk);
        #1;
        pulseStart();
        for (int k = 0; k < 5; k++) sendByte(pat(k));
        @(negedge clk);
        checkOutput("refill.wea", 64'(wea), 1);
        checkOutput("refill.addra", 64'(addra), 0);
        checkOutput("refill.dina", 64'(dina), 64'(wordOf(0)));
        @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
